// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, MEM-stage state, EX/MEM control bundle.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // IDLE: nothing outstanding; REQ: dcache request in flight; HELD: request done, waiting for en
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2
  } exmem_state_t;

  // Control bits carried from ID/EX into the EX/MEM entry
  typedef struct packed {
    logic regWEN;
    logic MemToReg;
    logic JType;
    logic Halt;
  } exmem_ctrl_t;

endpackage

// File: rtl/exmem_dreq_fsm.sv
// Data-memory request sequencer: tracks the outstanding dcache access and a pending flush.
// Latency: strobes rise the edge after accept; mem_stall drops combinationally with dhit.
// Backpressure: holds strobes stable until dhit; accept is gated while a request is in flight or halted.
module exmem_dreq_fsm
  import cpu_types_pkg::*;
(
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  input  logic         flush,
  input  logic         dhit,
  input  logic         dMemREN_in,
  input  logic         dMemWEN_in,
  input  logic         halted,
  output exmem_state_t state,
  output logic         accept,
  output logic         done,
  output logic         bubble,
  output logic         pend_flush,
  output logic         ren_r,
  output logic         wen_r,
  output logic         mem_stall,
  output logic         dmemREN,
  output logic         dmemWEN
);

  // Flush outranks a new entry; nothing new enters while busy or after halt
  assign accept    = en & (state != REQ) & ~halted & ~flush;
  assign done      = (state == REQ) & dhit;
  // A flush seen earlier in the request or on the dhit cycle itself kills the entry
  assign bubble    = pend_flush | flush;
  assign mem_stall = (state == REQ) & ~dhit;
  // ren_r/wen_r are only ever set while in REQ, so they drive the strobes directly
  assign dmemREN   = ren_r;
  assign dmemWEN   = wen_r;

  // Request state, strobe registers and deferred-flush flag
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      ren_r      <= 1'b0;
      wen_r      <= 1'b0;
      pend_flush <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (dhit) begin
            ren_r      <= 1'b0;
            wen_r      <= 1'b0;
            pend_flush <= 1'b0;
            state      <= en ? IDLE : HELD;
          end else if (flush) begin
            pend_flush <= 1'b1;
          end
        end
        default: begin
          if (flush) begin
            ren_r <= 1'b0;
            wen_r <= 1'b0;
          end else if (accept) begin
            // Read wins if both strobes arrive together; the write is dropped
            ren_r <= dMemREN_in;
            wen_r <= dMemWEN_in & ~dMemREN_in;
            state <= (dMemREN_in | dMemWEN_in) ? REQ : IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/exmem_dreq.sv
// EX/MEM pipeline register fused with the dcache request controller.
// Latency: ALU entries visible 1 edge after accept; load data 1 edge after dhit.
// Backpressure: mem_stall high while a request waits for dhit; entries wait in HELD until en.
module exmem_dreq
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     en,
  input  logic     flush,
  input  word_t    aluout_in,
  input  word_t    rdat2_in,
  input  word_t    pcplus4_in,
  input  regbits_t writeReg_in,
  input  logic     regWEN_in,
  input  logic     MemToReg_in,
  input  logic     JType_in,
  input  logic     dMemREN_in,
  input  logic     dMemWEN_in,
  input  logic     Halt_in,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output word_t    aluout_out,
  output word_t    pcplus4_out,
  output word_t    load_out,
  output word_t    wdat_out,
  output regbits_t writeReg_out,
  output logic     regWEN_out,
  output logic     MemToReg_out,
  output logic     JType_out,
  output logic     Halt_out,
  output logic     mem_stall
);

  exmem_state_t state;
  logic         accept;
  logic         done;
  logic         bubble;
  logic         pend_flush;
  logic         ren_r;
  logic         wen_r;

  exmem_ctrl_t  ctrl_r;
  word_t        aluout_r;
  word_t        pcplus4_r;
  word_t        load_r;
  word_t        rdat2_r;
  regbits_t     wreg_r;

  exmem_dreq_fsm u_fsm (
    .CLK        (CLK),
    .nRST       (nRST),
    .en         (en),
    .flush      (flush),
    .dhit       (dhit),
    .dMemREN_in (dMemREN_in),
    .dMemWEN_in (dMemWEN_in),
    .halted     (ctrl_r.Halt),
    .state      (state),
    .accept     (accept),
    .done       (done),
    .bubble     (bubble),
    .pend_flush (pend_flush),
    .ren_r      (ren_r),
    .wen_r      (wen_r),
    .mem_stall  (mem_stall),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN)
  );

  // Entry registers: flush clears the visible destination/control, accept loads, dhit lands load data
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ctrl_r    <= '0;
      aluout_r  <= '0;
      pcplus4_r <= '0;
      load_r    <= '0;
      rdat2_r   <= '0;
      wreg_r    <= '0;
    end else if (flush && (state != REQ)) begin
      // Halt survives a flush so a halting entry is never lost
      ctrl_r.regWEN   <= 1'b0;
      ctrl_r.MemToReg <= 1'b0;
      ctrl_r.JType    <= 1'b0;
      wreg_r          <= '0;
      aluout_r        <= '0;
    end else if (accept) begin
      ctrl_r.regWEN   <= regWEN_in;
      ctrl_r.MemToReg <= MemToReg_in;
      ctrl_r.JType    <= JType_in;
      ctrl_r.Halt     <= Halt_in;
      aluout_r        <= aluout_in;
      pcplus4_r       <= pcplus4_in;
      rdat2_r         <= rdat2_in;
      wreg_r          <= writeReg_in;
      load_r          <= '0;
    end else if (done) begin
      // A flushed entry still finishes its access but must not write back
      if (bubble) begin
        ctrl_r.regWEN <= 1'b0;
      end else if (ren_r) begin
        load_r <= dmemload;
      end
    end
  end

  assign dmemaddr     = aluout_r;
  assign dmemstore    = rdat2_r;
  assign aluout_out   = aluout_r;
  assign pcplus4_out  = pcplus4_r;
  assign load_out     = load_r;
  assign wdat_out     = ctrl_r.MemToReg ? load_r : aluout_r;
  assign writeReg_out = wreg_r;
  assign regWEN_out   = ctrl_r.regWEN;
  assign MemToReg_out = ctrl_r.MemToReg;
  assign JType_out    = ctrl_r.JType;
  assign Halt_out     = ctrl_r.Halt;

endmodule

// File: doc/exmem_dreq.md
Name: exmem_dreq

Overview:
- EX/MEM pipeline register fused with the data-memory request controller; sits directly downstream of the ID/EX latch and the ALU, and feeds the MEM/WB latch.
- Captures EX results, issues one dcache read or write per memory instruction, holds it until dhit, and raises mem_stall to the hazard unit while waiting.
- Latches load data so writeback and forwarding see a stable value even when the downstream pipeline is frozen.

Parameters:
- WORD_W, 32, data/address width (word_t)
- REG_W, 5, register-index width (regbits_t)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  synchronous active-low reset
- en  in  1  writeEN from hazard unit; load a new entry
- flush  in  1  replace entry with bubble
- aluout_in  in  WORD_W  ALU result / effective address
- rdat2_in  in  WORD_W  store data
- pcplus4_in  in  WORD_W  link value for JAL
- writeReg_in  in  REG_W  destination register
- regWEN_in, MemToReg_in, JType_in, dMemREN_in, dMemWEN_in, Halt_in  in  1 each  control from ID/EX
- dhit  in  1  dcache hit/done
- dmemload  in  WORD_W  dcache read data
- dmemREN, dmemWEN  out  1 each  dcache request strobes
- dmemaddr, dmemstore  out  WORD_W  request address / store data
- aluout_out, pcplus4_out, load_out  out  WORD_W  registered values to MEM/WB
- wdat_out  out  WORD_W  forwarding value: MemToReg_out ? load_out : aluout_out
- writeReg_out  out  REG_W
- regWEN_out, MemToReg_out, JType_out, Halt_out  out  1 each
- mem_stall  out  1  memory stage busy

Behaviour:
- Reset: synchronous only; at a rising edge with nRST=0, every registered output goes to 0, the state goes to IDLE, and pend_flush is cleared. nRST has priority over every other input.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - HELD: request done; the entry is waiting for en.
- Accept condition: accept = en & (state!=REQ) & !Halt_out. On accept, load all *_in into their *_out registers, load ren_r/wen_r from dMemREN_in/dMemWEN_in, and set load_out to 0.
- Next state after accept: REQ if dMemREN_in|dMemWEN_in, else IDLE. Both strobes set at once is illegal; the read takes priority and the write is dropped.
- REQ:
  - dmemREN = ren_r, dmemWEN = wen_r, dmemaddr = aluout_out, dmemstore = rdat2 register.
  - Strobes stay stable until dhit.
  - On the dhit edge: load_out <= dmemload if ren_r; clear ren_r and wen_r; go to HELD. If en is also high that cycle, go to IDLE instead and the entry counts as consumed.
- HELD: strobes are low; the entry behaves as IDLE for accept purposes.
- mem_stall = (state==REQ) & !dhit, purely combinational. The stage therefore adds 0 stall cycles when dhit arrives in the same cycle as the request. Upstream en must be low while mem_stall is high; the block also gates accept internally.
- dhit outside REQ is ignored.
- Latency: a non-memory entry appears on the outputs at the edge after accept. A memory entry's load_out is valid the edge after dhit.
- Flush:
  - Flush in IDLE or HELD clears regWEN_out, MemToReg_out, JType_out, ren_r, wen_r, writeReg_out and aluout_out at the next edge. Halt_out is not cleared. Flush has priority over accept.
  - Flush in REQ sets pend_flush. The request still completes, so stores are never torn. At dhit, the entry becomes a bubble: regWEN_out=0 and load_out not updated. pend_flush then clears.
- Halt: once Halt_out=1 it is sticky until reset. No further accepts happen. An outstanding request still completes.
- Simultaneous events:
  - Reset beats everything.
  - dhit+flush in REQ: apply the bubble and complete the request.
  - en+flush in IDLE: flush wins.

Decomposition:
- word_t, regbits_t and the MEM-stage state enum (exmem_state_t: IDLE, REQ, HELD) belong in cpu_types_pkg.
- One sub-module is natural: dreq_fsm (state, ren_r/wen_r, pend_flush, mem_stall, strobes). exmem_dreq holds the data registers and the wdat_out mux.

Test Plan:
- Reset then ALU op: after nRST=0 for 2 cycles, all outputs are 0. Then en=1, aluout_in=0x00000010, regWEN_in=1, writeReg_in=5 -> next edge aluout_out=0x10, regWEN_out=1, mem_stall=0, no strobes.
- Load with 3-cycle miss: en=1, dMemREN_in=1, MemToReg_in=1, aluout_in=0x100 -> dmemREN=1 and dmemaddr=0x100 for 3 cycles with mem_stall=1. dhit arrives with dmemload=0xDEADBEEF -> mem_stall drops that cycle; next edge load_out=wdat_out=0xDEADBEEF, dmemREN=0.
- Store, immediate hit: dMemWEN_in=1, aluout_in=0x200, rdat2_in=0x12345678, dhit high same cycle -> dmemWEN one cycle, dmemstore=0x12345678, mem_stall never 1.
- Flush during REQ: load pending, assert flush for 1 cycle, dhit 2 cycles later -> request completes, regWEN_out=0, load_out unchanged.
- HELD: dhit while en=0 -> state HELD, strobes low, no reissue. en=1 with a new ALU op -> that entry is accepted.
- Sync reset mid-REQ and Halt: nRST low during REQ -> strobes 0 at next edge, not before. Halt_in accepted -> Halt_out=1; later en pulses ignored until reset.
